xdma_c2h_arbiter: RTL and testbench

XDMA_C2H_ARBITER -- requirements
Module: xdma_c2h_arbiter

---
 rtl/xdma_bpu_pkg.sv | 12 +
 rtl/axis_skid_buf.sv | 73 +++++++
 rtl/xdma_c2h_arbiter.sv | 135 +++++++++++++
 tb/tb_xdma_c2h_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_bpu_pkg.sv
// Shared definitions for the C2H stream arbiter: FSM state encoding and
// the upper bound on the number of requesters.
package xdma_bpu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_e;

    localparam int MAX_NUM_SRC = 8;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer carrying tdata/tkeep/tlast.
// The output register gives one cycle of latency; the skid register catches
// the single beat that may arrive while the output is stalled, so in_ready
// can be a flop instead of a combinational copy of out_tready.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_tdata,
    input  logic [DATA_WIDTH/8-1:0] in_tkeep,
    input  logic                    in_tlast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic [DATA_WIDTH/8-1:0] out_tkeep,
    output logic                    out_tlast,
    output logic                    out_tvalid,
    input  logic                    out_tready
);

    localparam int BEAT_W = DATA_WIDTH + DATA_WIDTH / 8 + 1;

    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] main_q;
    logic [BEAT_W-1:0] skid_q;
    logic              main_valid;
    logic              skid_valid;
    logic              in_ready_r;
    logic              in_fire;

    assign in_beat  = {in_tlast, in_tkeep, in_tdata};
    assign in_fire  = in_valid && in_ready_r;
    assign in_ready = in_ready_r;

    assign out_tvalid = main_valid;
    assign out_tlast  = main_q[BEAT_W-1];
    assign out_tkeep  = main_q[DATA_WIDTH +: DATA_WIDTH/8];
    assign out_tdata  = main_q[DATA_WIDTH-1:0];

    // Output register refills from the skid entry first (preserving order),
    // otherwise from the input; a beat arriving during a stall parks in skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_valid <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            in_ready_r <= 1'b0;
        end else if (!main_valid || out_tready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire) begin
                    main_q <= in_beat;
                end
            end
            in_ready_r <= 1'b1;
        end else begin
            if (in_fire) begin
                skid_q     <= in_beat;
                skid_valid <= 1'b1;
                in_ready_r <= 1'b0;
            end else begin
                in_ready_r <= !skid_valid;
            end
        end
    end

endmodule

// File: rtl/xdma_c2h_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_SRC AXI-Stream requesters
// onto XDMA C2H channel 0 through a registered skid buffer.
//
// Handshake: a beat moves on any AXI-Stream interface in the cycle where
// valid and ready are both high at the rising edge; valid never waits on
// ready, and an offered beat holds its payload until it is taken.
module xdma_c2h_arbiter
    import xdma_bpu_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                            user_clk,
    input  logic                            user_reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_c2h_tdata_0,
    output logic [DATA_WIDTH/8-1:0]         m_axis_c2h_tkeep_0,
    output logic                            m_axis_c2h_tlast_0,
    output logic                            m_axis_c2h_tvalid_0,
    input  logic                            m_axis_c2h_tready_0,
    output logic [$clog2(NUM_SRC)-1:0]      grant_id,
    output logic                            busy,
    output logic                            pkt_done,
    output state_e                          fsm_state
);

    localparam int ID_W   = $clog2(NUM_SRC);
    localparam int KEEP_W = DATA_WIDTH / 8;

    state_e              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     sel_id;
    logic [ID_W-1:0]     cand;
    logic                sel_found;
    logic [DATA_WIDTH-1:0] g_tdata;
    logic [KEEP_W-1:0]   g_tkeep;
    logic                g_tlast;
    logic                g_tvalid;
    logic                skid_in_valid;
    logic                skid_in_ready;
    logic                in_fire;

    assign fsm_state = state;

    // Round-robin pick: first requester at or above rr_ptr, wrapping to 0.
    // The loop is bounded by the package maximum so it unrolls the same way
    // for every NUM_SRC.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = rr_ptr;
        cand      = '0;
        for (int i = 0; i < MAX_NUM_SRC; i++) begin
            if (i < NUM_SRC) begin
                cand = ID_W'((int'(rr_ptr) + i) % NUM_SRC);
                if (!sel_found && s_axis_tvalid[cand]) begin
                    sel_found = 1'b1;
                    sel_id    = cand;
                end
            end
        end
    end

    // Steer the granted source's beat toward the skid buffer.
    always_comb begin
        g_tdata  = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        g_tkeep  = s_axis_tkeep[grant_id*KEEP_W +: KEEP_W];
        g_tlast  = s_axis_tlast[grant_id];
        g_tvalid = s_axis_tvalid[grant_id];
    end

    assign skid_in_valid = (state == PASS) && g_tvalid;
    assign in_fire       = skid_in_valid && skid_in_ready;
    assign pkt_done      = in_fire && g_tlast;

    // Only the granted source sees ready, and only while a grant is held.
    always_comb begin
        s_axis_tready = '0;
        if (state == PASS) begin
            s_axis_tready[grant_id] = skid_in_ready;
        end
    end

    // Arbitration FSM: one IDLE decision cycle, then PASS until tlast moves.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel_id;
                        busy     <= 1'b1;
                        state    <= PASS;
                    end
                end
                PASS: begin
                    if (pkt_done) begin
                        rr_ptr <= (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    axis_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (user_clk),
        .rst        (user_reset),
        .in_tdata   (g_tdata),
        .in_tkeep   (g_tkeep),
        .in_tlast   (g_tlast),
        .in_valid   (skid_in_valid),
        .in_ready   (skid_in_ready),
        .out_tdata  (m_axis_c2h_tdata_0),
        .out_tkeep  (m_axis_c2h_tkeep_0),
        .out_tlast  (m_axis_c2h_tlast_0),
        .out_tvalid (m_axis_c2h_tvalid_0),
        .out_tready (m_axis_c2h_tready_0)
    );

endmodule

// File: tb/tb_xdma_c2h_arbiter.sv
// Bench for xdma_c2h_arbiter: per-source packet queues drive the inputs,
// expected output beats and grant ids are queued in arbitration order, and a
// monitor pops and compares them as the DUT emits beats and pkt_done pulses.
module tb_xdma_c2h_arbiter;
    import xdma_bpu_pkg::*;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic              user_clk = 1'b0;
    logic              user_reset;
    logic [NS*DW-1:0]  s_axis_tdata;
    logic [NS*KW-1:0]  s_axis_tkeep;
    logic [NS-1:0]     s_axis_tlast;
    logic [NS-1:0]     s_axis_tvalid;
    logic [NS-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_c2h_tdata_0;
    logic [KW-1:0]     m_axis_c2h_tkeep_0;
    logic              m_axis_c2h_tlast_0;
    logic              m_axis_c2h_tvalid_0;
    logic              m_axis_c2h_tready_0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              pkt_done;
    state_e            fsm_state;

    // {gap[3:0], last, data[63:0]}: gap = idle cycles before offering the beat
    logic [68:0] src_q[NS][$];
    logic [72:0] exp_q[$];        // {last, keep, data}
    logic [1:0]  exp_grant_q[$];
    int          fire_cyc[$];

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    logic bp_mode      = 1'b0;
    logic [3:0] bp_pat = 4'b1001; // tready per cycle: 1,0,0,1,...

    xdma_c2h_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
        .user_clk            (user_clk),
        .user_reset          (user_reset),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .m_axis_c2h_tdata_0  (m_axis_c2h_tdata_0),
        .m_axis_c2h_tkeep_0  (m_axis_c2h_tkeep_0),
        .m_axis_c2h_tlast_0  (m_axis_c2h_tlast_0),
        .m_axis_c2h_tvalid_0 (m_axis_c2h_tvalid_0),
        .m_axis_c2h_tready_0 (m_axis_c2h_tready_0),
        .grant_id            (grant_id),
        .busy                (busy),
        .pkt_done            (pkt_done),
        .fsm_state           (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 user_clk = ~user_clk;
    initial forever begin
        @(posedge user_clk);
        cyc++;
    end

    // ---------------- source / sink driver ----------------
    initial begin : drv
        logic [NS-1:0] fire_s;
        logic [68:0]   f;
        s_axis_tdata        = '0;
        s_axis_tkeep        = '0;
        s_axis_tlast        = '0;
        s_axis_tvalid       = '0;
        m_axis_c2h_tready_0 = 1'b1;
        forever begin
            @(negedge user_clk);
            fire_s = s_axis_tvalid & s_axis_tready;
            @(posedge user_clk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (fire_s[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
                if (src_q[s].size() == 0) begin
                    s_axis_tvalid[s] = 1'b0;
                end else begin
                    f = src_q[s][0];
                    if (f[68:65] != 4'd0) begin
                        f[68:65] = f[68:65] - 4'd1;
                        src_q[s][0] = f;
                        s_axis_tvalid[s] = 1'b0;
                    end else begin
                        s_axis_tvalid[s]         = 1'b1;
                        s_axis_tdata[s*DW +: DW] = f[63:0];
                        s_axis_tkeep[s*KW +: KW] = f[7:0];
                        s_axis_tlast[s]          = f[64];
                    end
                end
            end
            m_axis_c2h_tready_0 = bp_mode ? bp_pat[cyc % 4] : 1'b1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : mon
        logic        prev_stall;
        logic [72:0] prev_out;
        logic [72:0] got;
        logic [72:0] e;
        logic [1:0]  g;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge user_clk);
            if (user_reset) begin
                prev_stall = 1'b0;
            end else begin
                got = {m_axis_c2h_tlast_0, m_axis_c2h_tkeep_0, m_axis_c2h_tdata_0};
                if (prev_stall) begin
                    tests_run++;
                    if (got !== prev_out || m_axis_c2h_tvalid_0 !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL stall_hold: got v=%b %h want v=1 %h", m_axis_c2h_tvalid_0, got, prev_out);
                    end
                end
                prev_stall = m_axis_c2h_tvalid_0 && !m_axis_c2h_tready_0;
                prev_out   = got;
                if (m_axis_c2h_tvalid_0 && m_axis_c2h_tready_0) begin
                    fire_cyc.push_back(cyc);
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL out_beat: got unexpected %h want no beat", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            tests_failed++;
                            $display("FAIL out_beat: got %h want %h", got, e);
                        end
                    end
                end
                if (pkt_done === 1'b1) begin
                    tests_run++;
                    if (exp_grant_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL pkt_done: got unexpected pulse grant=%0d want none", grant_id);
                    end else begin
                        g = exp_grant_q.pop_front();
                        if (grant_id !== g) begin
                            tests_failed++;
                            $display("FAIL grant_order: got %0d want %0d", grant_id, g);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic add_pkt(input int s, input int p, input int nbeats,
                           input int gap_at, input int gap_len);
        logic [63:0] d;
        logic        last;
        for (int b = 0; b < nbeats; b++) begin
            d    = {32'($urandom()), 8'(s), 8'(p), 8'(b), 8'($urandom_range(1, 255))};
            last = (b == nbeats - 1);
            src_q[s].push_back({4'((b == gap_at) ? gap_len : 0), last, d});
            exp_q.push_back({last, d[7:0], d});
        end
        exp_grant_q.push_back(2'(s));
    endtask

    task automatic clear_all();
        for (int s = 0; s < NS; s++) src_q[s].delete();
        exp_q.delete();
        exp_grant_q.delete();
        fire_cyc.delete();
        bp_mode = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge user_clk); #1;
        user_reset = 1'b1;
        clear_all();
        repeat (2) @(negedge user_clk);
        #1;
        user_reset = 1'b0;
        @(negedge user_clk); #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < budget) begin
            @(negedge user_clk); #1;
            n++;
            pend = exp_q.size();
            for (int s = 0; s < NS; s++) pend += src_q[s].size();
        end
        tests_run++;
        if (pend != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d beats pending after %0d cycles want 0", name, pend, budget);
        end
        repeat (3) @(negedge user_clk);
        #1;
        tests_run++;
        if (exp_grant_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_pkt_done: got %0d packets without pkt_done want 0", name, exp_grant_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        user_reset = 1'b1;
        clear_all();
        repeat (2) @(negedge user_clk);
        #1;
        tests_run++;
        if (m_axis_c2h_tvalid_0 !== 1'b0 || m_axis_c2h_tdata_0 !== '0 ||
            m_axis_c2h_tkeep_0 !== '0 || m_axis_c2h_tlast_0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out: got v=%b d=%h k=%h l=%b want all 0", m_axis_c2h_tvalid_0,
                     m_axis_c2h_tdata_0, m_axis_c2h_tkeep_0, m_axis_c2h_tlast_0);
        end
        tests_run++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || pkt_done !== 1'b0 || fsm_state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got busy=%b grant=%0d done=%b st=%0d want 0 0 0 IDLE",
                     busy, grant_id, pkt_done, fsm_state);
        end
        // a request present during reset must not be granted before release
        add_pkt(1, 0, 1, -1, 0);
        repeat (2) @(negedge user_clk);
        #1;
        tests_run++;
        if (s_axis_tready !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got tready=%b busy=%b want 0000 0", s_axis_tready, busy);
        end
        user_reset = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_no_edge: got busy=%b want 0", busy);
        end
        @(negedge user_clk); #1;
        tests_run++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || fsm_state !== PASS) begin
            tests_failed++;
            $display("FAIL first_grant: got busy=%b grant=%0d st=%0d want 1 1 PASS", busy, grant_id, fsm_state);
        end
        wait_drain("reset", 50);
    endtask

    task automatic test_two_src();
        int exp_d[7] = '{1, 1, 1, 2, 1, 1, 1};
        do_reset();
        add_pkt(0, 0, 4, -1, 0);
        add_pkt(2, 0, 4, -1, 0);
        wait_drain("two_src", 100);
        tests_run++;
        if (fire_cyc.size() != 8) begin
            tests_failed++;
            $display("FAIL two_src_count: got %0d beats want 8", fire_cyc.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                tests_run++;
                if (fire_cyc[i+1] - fire_cyc[i] != exp_d[i]) begin
                    tests_failed++;
                    $display("FAIL two_src_spacing[%0d]: got %0d want %0d", i, fire_cyc[i+1] - fire_cyc[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int s = 0; s < NS; s++)
                add_pkt(s, p, 2, -1, 0);
        wait_drain("round_robin", 400);
    endtask

    task automatic test_valid_drop();
        do_reset();
        add_pkt(1, 0, 4, 2, 3);
        add_pkt(3, 0, 2, -1, 0);
        wait_drain("valid_drop", 100);
    endtask

    task automatic test_backpressure();
        do_reset();
        bp_mode = 1'b1;
        add_pkt(0, 0, 8, -1, 0);
        wait_drain("backpressure", 200);
        bp_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        add_pkt(2, 0, 2, -1, 0);   // leaves rr_ptr at 3
        wait_drain("reset_mid_pre", 50);
        add_pkt(0, 1, 5, -1, 0);
        n = 0;
        while (exp_q.size() > 3 && n < 100) begin
            @(negedge user_clk); #1;
            n++;
        end
        tests_run++;
        if (exp_q.size() > 3) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got %0d beats left want 3", exp_q.size());
        end
        user_reset = 1'b1;
        clear_all();
        #1;
        tests_run++;
        if (m_axis_c2h_tvalid_0 !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 4'b0000 ||
            pkt_done !== 1'b0 || m_axis_c2h_tdata_0 !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_out: got v=%b busy=%b rdy=%b done=%b d=%h want 0 0 0000 0 0",
                     m_axis_c2h_tvalid_0, busy, s_axis_tready, pkt_done, m_axis_c2h_tdata_0);
        end
        repeat (2) @(negedge user_clk);
        #1;
        user_reset = 1'b0;
        // rr_ptr back at 0: source 1 wins over source 3
        add_pkt(1, 2, 2, -1, 0);
        add_pkt(3, 2, 2, -1, 0);
        wait_drain("reset_mid_post", 100);
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int k = 0; k < 6; k++) add_pkt(3, k, 1, -1, 0);
        wait_drain("single_beat", 100);
        tests_run++;
        if (fire_cyc.size() != 6) begin
            tests_failed++;
            $display("FAIL single_count: got %0d beats want 6", fire_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (fire_cyc[i+1] - fire_cyc[i] != 2) begin
                    tests_failed++;
                    $display("FAIL single_spacing[%0d]: got %0d want 2", i, fire_cyc[i+1] - fire_cyc[i]);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        user_reset = 1'b1;
        test_reset();
        test_two_src();
        test_round_robin();
        test_valid_drop();
        test_backpressure();
        test_reset_mid();
        test_single_beat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog: got no completion want finish before 50000 cycles");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
